// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: NREQ execution units, each with a one-entry
// holding buffer, share the ROB's single registered writeback port.
module wb_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rob_flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [7*NREQ-1:0]    req_robid,
    input  logic [32*NREQ-1:0]   req_result,
    input  logic [NREQ-1:0]      req_error,
    input  logic [5*NREQ-1:0]    req_ecause,
    output logic                 wb_valid,
    output logic [6:0]           wb_robid,
    output logic [31:0]          wb_result,
    output logic                 wb_error,
    output logic [4:0]           wb_ecause,
    output logic [2:0]           wb_unit
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] hb_valid;
    logic [6:0]      hb_robid  [NREQ];
    logic [31:0]     hb_result [NREQ];
    logic            hb_error  [NREQ];
    logic [4:0]      hb_ecause [NREQ];

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   grant_sel;
    logic [NREQ-1:0] mask_hi;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] beat;
    logic            any_grant;

    // Rotating priority: prefer the lowest valid unit at or above ptr, else
    // wrap to the lowest valid unit overall; isolate that single bit.
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mask_hi   = '0;
        grant_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            mask_hi[i] = (PW'(i) >= ptr);
        end
        hi_req    = hb_valid & mask_hi;
        pick      = (|hi_req) ? hi_req : hb_valid;
        grant     = (rst || rob_flush) ? '0 : (pick & (~pick + NREQ'(1)));
        any_grant = |grant;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_sel = PW'(i);
        end
        ptr_next  = (grant_sel == PW'(NREQ - 1)) ? '0 : grant_sel + PW'(1);
    end

    // A granted buffer drains this cycle, so it can reload in the same cycle.
    assign req_ready = {NREQ{~rob_flush}} & ({NREQ{rst}} | ~hb_valid | grant);
    assign beat      = req_valid & req_ready & {NREQ{~rst}};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_valid  <= '0;
            ptr       <= '0;
            wb_valid  <= 1'b0;
            wb_robid  <= '0;
            wb_result <= '0;
            wb_error  <= 1'b0;
            wb_ecause <= '0;
            wb_unit   <= '0;
        end else begin
            wb_valid <= any_grant;
            if (any_grant) begin
                wb_robid  <= hb_robid[grant_sel];
                wb_result <= hb_result[grant_sel];
                wb_error  <= hb_error[grant_sel];
                wb_ecause <= hb_ecause[grant_sel];
                wb_unit   <= 3'(grant_sel);
                ptr       <= ptr_next;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (rob_flush)     hb_valid[i] <= 1'b0;
                else if (beat[i])  hb_valid[i] <= 1'b1;
                else if (grant[i]) hb_valid[i] <= 1'b0;
            end
        end
    end

    // NOTE: buffer payloads are not reset; hb_valid alone qualifies them, so
    // resetting the storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (beat[i]) begin
                hb_robid[i]  <= req_robid[7*i +: 7];
                hb_result[i] <= req_result[32*i +: 32];
                hb_error[i]  <= req_error[i];
                hb_ecause[i] <= req_ecause[5*i +: 5];
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_wb_arbiter;

    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rob_flush = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [7*NREQ-1:0]   req_robid = '0;
    logic [32*NREQ-1:0]  req_result = '0;
    logic [NREQ-1:0]     req_error = '0;
    logic [5*NREQ-1:0]   req_ecause = '0;
    logic                wb_valid;
    logic [6:0]          wb_robid;
    logic [31:0]         wb_result;
    logic                wb_error;
    logic [4:0]          wb_ecause;
    logic [2:0]          wb_unit;

    wb_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .rob_flush(rob_flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_robid(req_robid), .req_result(req_result),
        .req_error(req_error), .req_ecause(req_ecause),
        .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_result(wb_result),
        .wb_error(wb_error), .wb_ecause(wb_ecause), .wb_unit(wb_unit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  robid;
        logic [31:0] result;
        logic        err;
        logic [4:0]  ecause;
        logic [2:0]  unit;
    } item_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-unit source queues: the head is presented until it is accepted.
    item_t src_q [NREQ][$];
    item_t wb_log[$];

    // Model state: what each holding buffer holds and what the port shows.
    bit    m_hb_v  [NREQ];
    item_t m_hb    [NREQ];
    int    m_since [NREQ];
    int    m_ptr = 0;
    bit    m_wb_v = 0;
    item_t m_wb = '0;
    int    cyc = 0;
    int    max_wait = 0;
    int    m_acc = 0;
    int    m_drop = 0;
    int    dut_pulses = 0;

    function automatic int model_grant();
        if (rst || rob_flush) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (m_hb_v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        int g;
        g = model_grant();
        for (int i = 0; i < NREQ; i++)
            r[i] = !rob_flush && (rst || !m_hb_v[i] || g == i);
        return r;
    endfunction

    always @(posedge clk) begin : model
        int g;
        logic [NREQ-1:0] rdy;
        g   = model_grant();
        rdy = model_ready();
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_hb_v[i]) m_drop++;
                m_hb_v[i] = 0;
            end
            m_ptr  = 0;
            m_wb_v = 0;
            m_wb   = '0;
        end else begin
            m_wb_v = (g >= 0);
            if (g >= 0) begin
                if (cyc - m_since[g] > max_wait) max_wait = cyc - m_since[g];
                m_wb      = m_hb[g];
                m_wb.unit = 3'(g);
                m_ptr     = (g + 1) % NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (rob_flush) begin
                    if (m_hb_v[i]) m_drop++;
                    m_hb_v[i] = 0;
                end else if (req_valid[i] && rdy[i]) begin
                    m_hb[i].robid  = req_robid[7*i +: 7];
                    m_hb[i].result = req_result[32*i +: 32];
                    m_hb[i].err    = req_error[i];
                    m_hb[i].ecause = req_ecause[5*i +: 5];
                    m_hb_v[i]  = 1;
                    m_since[i] = cyc + 1;
                    m_acc++;
                    void'(src_q[i].pop_front());
                end else if (g == i) begin
                    m_hb_v[i] = 0;
                end
            end
        end
        cyc++;
    end

    // Driver: present each unit's queue head shortly after the edge.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() != 0) begin
                req_valid[i]           = 1'b1;
                req_robid[7*i +: 7]    = src_q[i][0].robid;
                req_result[32*i +: 32] = src_q[i][0].result;
                req_error[i]           = src_q[i][0].err;
                req_ecause[5*i +: 5]   = src_q[i][0].ecause;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        check("req_ready", req_ready, model_ready());
        check("wb_valid", wb_valid, m_wb_v);
        if (m_wb_v) begin
            check("wb_robid", wb_robid, m_wb.robid);
            check("wb_result", wb_result, m_wb.result);
            check("wb_error", wb_error, m_wb.err);
            check("wb_ecause", wb_ecause, m_wb.ecause);
            check("wb_unit", wb_unit, m_wb.unit);
        end
        if (wb_valid) begin
            dut_pulses++;
            wb_log.push_back({wb_robid, wb_result, wb_error, wb_ecause, wb_unit});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int u, input logic [6:0] robid, input logic [31:0] res,
                        input logic err, input logic [4:0] ec);
        item_t it;
        it = '{robid: robid, result: res, err: err, ecause: ec, unit: 3'(u)};
        src_q[u].push_back(it);
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (wb_log.size() < n && k < budget) begin
            step();
            k++;
        end
        if (wb_log.size() < n) check("wait_log_timeout", wb_log.size(), n);
    endtask

    function automatic logic tb_busy();
        logic b;
        b = wb_valid | m_wb_v;
        for (int i = 0; i < NREQ; i++) b = b | (src_q[i].size() != 0) | m_hb_v[i];
        return b;
    endfunction

    task automatic drain();
        int k;
        k = 0;
        while (tb_busy() && k < 200) begin
            step();
            k++;
        end
        if (tb_busy()) check("drain_busy", tb_busy(), 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Single result through unit 2.
        repeat (3) step();
        rst = 1'b0;
        push(2, 7'h15, 32'hDEADBEEF, 1'b0, 5'h00);
        #2;
        check("single_ready_all_after_rst", req_ready, 4'b1111);
        step();
        #2;
        check("single_ready2_grant", req_ready[2], 1'b1);
        check("single_no_bypass", wb_valid, 1'b0);
        step();
        check("single_wb_valid", wb_valid, 1'b1);
        check("single_robid", wb_robid, 7'h15);
        check("single_result", wb_result, 32'hDEADBEEF);
        check("single_unit", wb_unit, 3'd2);
        check("single_ptr", dut.ptr, 2'd3);
        step();
        check("single_pulse_one_cycle", wb_valid, 1'b0);

        // Round-robin wrap from ptr=0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_ptr_after_rst", dut.ptr, 2'd0);
        wb_log.delete();
        for (int i = 0; i < NREQ; i++) push(i, 7'(10 + i), $urandom, 1'b0, 5'h00);
        step();
        for (int k = 0; k < NREQ; k++) begin
            step();
            check("rr_valid", wb_valid, 1'b1);
            check("rr_robid", wb_robid, 7'(10 + k));
            check("rr_unit", wb_unit, 3'(k));
        end
        push(2, 7'd14, $urandom, 1'b0, 5'h00);
        wait_log(5, 20);
        check("rr_ptr_after_unit2", dut.ptr, 2'd3);
        push(3, 7'd20, $urandom, 1'b0, 5'h00);
        push(0, 7'd21, $urandom, 1'b0, 5'h00);
        wait_log(7, 20);
        if (wb_log.size() >= 7) begin
            check("rr_refill_first", {wb_log[5].unit, wb_log[5].robid}, {3'd3, 7'd20});
            check("rr_refill_second", {wb_log[6].unit, wb_log[6].robid}, {3'd0, 7'd21});
        end

        // Backpressure: units 0 and 1 stream; ptr=1 so unit 1 leads.
        drain();
        wb_log.delete();
        for (int j = 0; j < 6; j++) begin
            push(0, 7'(8'h30 + j), $urandom, 1'b0, 5'h00);
            push(1, 7'(8'h38 + j), $urandom, 1'b0, 5'h00);
        end
        wait_log(12, 60);
        for (int k = 0; k < 12 && k < wb_log.size(); k++) begin
            check("bp_unit", wb_log[k].unit, (k % 2 == 0) ? 3'd1 : 3'd0);
            check("bp_robid", wb_log[k].robid,
                  (k % 2 == 0) ? 7'(8'h38 + k / 2) : 7'(8'h30 + k / 2));
        end

        // Flush with all buffers full.
        drain();
        wb_log.delete();
        for (int i = 0; i < NREQ; i++) push(i, 7'(8'h50 + i), $urandom, 1'b0, 5'h00);
        step();
        rob_flush = 1'b1;
        #2;
        check("flush_ready_low", req_ready, 4'b0000);
        step();
        rob_flush = 1'b0;
        check("flush_wb_off_1", wb_valid, 1'b0);
        push(1, 7'h60, 32'hCAFEF00D, 1'b0, 5'h00);
        step();
        check("flush_wb_off_2", wb_valid, 1'b0);
        step();
        check("flush_new_valid", wb_valid, 1'b1);
        check("flush_new_robid", wb_robid, 7'h60);
        step();
        check("flush_log_count", wb_log.size(), 1);

        // Reset while busy, then reset together with flush.
        drain();
        for (int i = 0; i < NREQ; i++) begin
            push(i, 7'(8'h70 + 2 * i), $urandom, 1'b1, 5'(i));
            push(i, 7'(8'h71 + 2 * i), $urandom, 1'b0, 5'h00);
        end
        step();
        step();
        check("rstbusy_wb_valid", wb_valid, 1'b1);
        rst = 1'b1;
        #2;
        check("rstbusy_ready_ones", req_ready, 4'b1111);
        rob_flush = 1'b1;
        #1;
        check("rstflush_ready_low", req_ready, 4'b0000);
        step();
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_fields", {wb_robid, wb_result, wb_error, wb_ecause, wb_unit}, 48'h0);
        check("rst_ptr", dut.ptr, 2'd0);
        rst = 1'b0;
        rob_flush = 1'b0;
        #2;
        check("rst_ready_after", req_ready, 4'b1111);

        // Error passthrough.
        drain();
        wb_log.delete();
        push(1, 7'h22, 32'h12345678, 1'b1, 5'h0B);
        wait_log(1, 10);
        if (wb_log.size() >= 1) begin
            check("err_flag", wb_log[0].err, 1'b1);
            check("err_ecause", wb_log[0].ecause, 5'h0B);
            check("err_robid", wb_log[0].robid, 7'h22);
        end

        // Randomized run.
        drain();
        for (int c = 0; c < 10000; c++) begin
            step();
            rob_flush = ($urandom_range(99) < 3);
            for (int i = 0; i < NREQ; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(99) < 60)
                    push(i, 7'($urandom), $urandom, 1'($urandom), 5'($urandom));
            end
        end
        rob_flush = 1'b0;
        drain();
        step();
        check("delivered_once", dut_pulses, m_acc - m_drop);
        n_vec++;
        if (max_wait > NREQ) begin
            n_err++;
            $display("FAIL max_wait: got %0d cycles, required <= %0d", max_wait, NREQ);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
